// File: rtl/uivbuf_wr_ctrl_if.sv
// Handshake and status bundle between the frame-write index manager and its
// surroundings (VS source, write DMA, read-index stage).
interface uivbuf_wr_ctrl_if;
  logic        en_i;
  logic        vs_i;
  logic [7:0]  rd_bufn_i;
  logic        wr_ack_i;
  logic        wr_done_i;
  logic        wr_req_o;
  logic [7:0]  bufn_o;
  logic        buf_upd_o;
  logic [15:0] frame_cnt_o;
  logic [15:0] ovf_cnt_o;
  logic [15:0] skip_cnt_o;

  // Index-manager view.
  modport slave (
    input  en_i, vs_i, rd_bufn_i, wr_ack_i, wr_done_i,
    output wr_req_o, bufn_o, buf_upd_o, frame_cnt_o, ovf_cnt_o, skip_cnt_o
  );

  // Environment view: drives VS/enable/DMA responses, observes the index.
  modport master (
    output en_i, vs_i, rd_bufn_i, wr_ack_i, wr_done_i,
    input  wr_req_o, bufn_o, buf_upd_o, frame_cnt_o, ovf_cnt_o, skip_cnt_o
  );
endinterface

// File: rtl/uivbuf_wr_ctrl.sv
// Write-side frame-buffer index manager: waits for the active VS edge, requests a
// frame write from the DMA, and advances the write buffer index around the ring.
module uivbuf_wr_ctrl #(
  parameter int BUF_LENTH = 3,
  parameter bit VS_POS    = 1'b1,
  parameter bit SKIP_RD   = 1'b1
) (
  input logic            ui_clk,
  input logic            ui_rst,
  uivbuf_wr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_BUSY,
    S_NEXT
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(BUF_LENTH - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state_reg;
  logic        vs_d_reg;
  logic        wr_req_reg;
  logic [7:0]  bufn_reg;
  logic        buf_upd_reg;
  logic [15:0] frame_cnt_reg;
  logic [15:0] ovf_cnt_reg;
  logic [15:0] skip_cnt_reg;

  logic        vs_edge;
  logic [7:0]  bufn_next;
  logic        rd_hit;

  always_comb begin
    vs_edge   = VS_POS ? (bus.vs_i & ~vs_d_reg) : (~bus.vs_i & vs_d_reg);
    bufn_next = (bufn_reg == LAST_IDX) ? 8'd0 : bufn_reg + 8'd1;
    // Out-of-range read indices can never equal bufn_next, so they never block.
    rd_hit    = SKIP_RD & (bufn_next == bus.rd_bufn_i);
  end

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_reg     <= S_IDLE;
      vs_d_reg      <= 1'b0;
      wr_req_reg    <= 1'b0;
      bufn_reg      <= 8'd0;
      buf_upd_reg   <= 1'b0;
      frame_cnt_reg <= 16'd0;
      ovf_cnt_reg   <= 16'd0;
      skip_cnt_reg  <= 16'd0;
    end else begin
      vs_d_reg    <= bus.vs_i;
      buf_upd_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.en_i) begin
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.en_i) begin
            state_reg <= S_IDLE;
          end else if (vs_edge) begin
            state_reg  <= S_REQ;
            wr_req_reg <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.wr_ack_i) begin
            state_reg  <= S_BUSY;
            wr_req_reg <= 1'b0;
          end
        end
        S_BUSY: begin
          // Completion takes precedence over a coincident VS edge.
          if (bus.wr_done_i) begin
            state_reg <= S_NEXT;
          end else if (vs_edge && ovf_cnt_reg != CNT_MAX) begin
            ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
          end
        end
        S_NEXT: begin
          frame_cnt_reg <= frame_cnt_reg + 16'd1;
          if (rd_hit) begin
            if (skip_cnt_reg != CNT_MAX) begin
              skip_cnt_reg <= skip_cnt_reg + 16'd1;
            end
          end else begin
            bufn_reg    <= bufn_next;
            buf_upd_reg <= 1'b1;
          end
          state_reg <= bus.en_i ? S_WAIT : S_IDLE;
        end
        default: begin
          state_reg  <= S_IDLE;
          wr_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_req_o    = wr_req_reg;
  assign bus.bufn_o      = bufn_reg;
  assign bus.buf_upd_o   = buf_upd_reg;
  assign bus.frame_cnt_o = frame_cnt_reg;
  assign bus.ovf_cnt_o   = ovf_cnt_reg;
  assign bus.skip_cnt_o  = skip_cnt_reg;

endmodule

// File: tb/tb_uivbuf_wr_ctrl.sv
// Directed bench for uivbuf_wr_ctrl: one rising-VS/skip-enabled instance and one
// falling-VS/no-skip instance; index updates are matched against a queue.
module tb_uivbuf_wr_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uivbuf_wr_ctrl_if ifa ();
  uivbuf_wr_ctrl_if ifb ();

  uivbuf_wr_ctrl #(.BUF_LENTH(3), .VS_POS(1'b1), .SKIP_RD(1'b1)) u_dut_a (
    .ui_clk (clk),
    .ui_rst (rst),
    .bus    (ifa.slave)
  );

  uivbuf_wr_ctrl #(.BUF_LENTH(3), .VS_POS(1'b0), .SKIP_RD(1'b0)) u_dut_b (
    .ui_clk (clk),
    .ui_rst (rst),
    .bus    (ifb.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_ovf = 0;
  int exp_skip = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ring_tbl [7] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every buf_upd_o pulse on instance A must match the next queued index.
  always @(negedge clk) begin
    if (!rst && ifa.buf_upd_o === 1'b1) begin
      check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("sb_bufn", ifa.bufn_o, exp_q.pop_front());
      end
    end
  end

  task automatic run_frame(input int ack_wait, input bit early_done, input int extra_vs,
                           input bit vs_with_done, input logic [7:0] exp_bufn, input bit exp_upd);
    ifa.vs_i = 1'b1;
    tick();
    ifa.vs_i = 1'b0;
    for (int c = 0; c < ack_wait; c++) begin
      check("req_hold", ifa.wr_req_o, 1);
      if (early_done && c == 0) ifa.wr_done_i = 1'b1;
      tick();
      ifa.wr_done_i = 1'b0;
    end
    check("req_up", ifa.wr_req_o, 1);
    ifa.wr_ack_i = 1'b1;
    tick();
    ifa.wr_ack_i = 1'b0;
    check("req_drop", ifa.wr_req_o, 0);
    for (int e = 0; e < extra_vs; e++) begin
      ifa.vs_i = 1'b1;
      tick();
      ifa.vs_i = 1'b0;
      tick();
      exp_ovf++;
    end
    if (vs_with_done) ifa.vs_i = 1'b1;
    ifa.wr_done_i = 1'b1;
    tick();
    ifa.wr_done_i = 1'b0;
    ifa.vs_i = 1'b0;
    check("upd_early", ifa.buf_upd_o, 0);
    exp_frames++;
    if (exp_upd) exp_q.push_back(exp_bufn);
    else exp_skip++;
    tick();
    check("upd_pulse", ifa.buf_upd_o, 32'(exp_upd));
    check("bufn", ifa.bufn_o, exp_bufn);
    check("frame_cnt", ifa.frame_cnt_o, exp_frames);
    check("ovf_cnt", ifa.ovf_cnt_o, exp_ovf);
    check("skip_cnt", ifa.skip_cnt_o, exp_skip);
    tick();
    check("upd_clear", ifa.buf_upd_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifa.en_i = 1'b0; ifa.vs_i = 1'b0; ifa.rd_bufn_i = 8'd255;
    ifa.wr_ack_i = 1'b0; ifa.wr_done_i = 1'b0;
    ifb.en_i = 1'b0; ifb.vs_i = 1'b0; ifb.rd_bufn_i = 8'd255;
    ifb.wr_ack_i = 1'b0; ifb.wr_done_i = 1'b0;

    repeat (3) tick();
    check("rst_req", ifa.wr_req_o, 0);
    check("rst_bufn", ifa.bufn_o, 0);
    check("rst_upd", ifa.buf_upd_o, 0);
    check("rst_frame", ifa.frame_cnt_o, 0);
    rst = 1'b0;
    ifa.en_i = 1'b1;
    tick();

    // Basic ring: read index out of range, so nothing is skipped.
    for (int i = 0; i < 7; i++) begin
      run_frame(0, 1'b0, 0, 1'b0, ring_tbl[i], 1'b1);
    end
    check("ring_frames", ifa.frame_cnt_o, 7);

    // Slow ack with a stray early done.
    run_frame(10, 1'b1, 0, 1'b0, 8'd2, 1'b1);

    // Overrun: two extra edges, a third coincident with done.
    run_frame(0, 1'b0, 2, 1'b1, 8'd0, 1'b1);
    check("ovf_two", ifa.ovf_cnt_o, 2);

    // Read collision.
    run_frame(0, 1'b0, 0, 1'b0, 8'd1, 1'b1);
    ifa.rd_bufn_i = 8'd2;
    run_frame(0, 1'b0, 0, 1'b0, 8'd1, 1'b0);
    ifa.rd_bufn_i = 8'd0;
    run_frame(0, 1'b0, 0, 1'b0, 8'd2, 1'b1);

    // Disable while busy: frame completes, then idle.
    ifa.rd_bufn_i = 8'd255;
    ifa.vs_i = 1'b1;
    tick();
    ifa.vs_i = 1'b0;
    check("t5_req", ifa.wr_req_o, 1);
    ifa.wr_ack_i = 1'b1;
    tick();
    ifa.wr_ack_i = 1'b0;
    ifa.en_i = 1'b0;
    tick();
    tick();
    ifa.wr_done_i = 1'b1;
    exp_frames++;
    exp_q.push_back(8'd0);
    tick();
    ifa.wr_done_i = 1'b0;
    tick();
    check("t5_bufn", ifa.bufn_o, 0);
    check("t5_frame", ifa.frame_cnt_o, exp_frames);
    for (int k = 0; k < 3; k++) begin
      ifa.vs_i = 1'b1;
      tick();
      ifa.vs_i = 1'b0;
      tick();
      check("req_idle", ifa.wr_req_o, 0);
    end

    // Asynchronous reset while a request is pending.
    ifa.en_i = 1'b1;
    tick();
    ifa.vs_i = 1'b1;
    tick();
    ifa.vs_i = 1'b0;
    check("t5_req2", ifa.wr_req_o, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_req", ifa.wr_req_o, 0);
    check("arst_bufn", ifa.bufn_o, 0);
    check("arst_frame", ifa.frame_cnt_o, 0);
    check("arst_ovf", ifa.ovf_cnt_o, 0);
    check("arst_skip", ifa.skip_cnt_o, 0);
    exp_frames = 0; exp_ovf = 0; exp_skip = 0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("req_post_rst", ifa.wr_req_o, 0);

    // Falling-edge instance without read skipping.
    ifb.en_i = 1'b1;
    tick();
    ifb.vs_i = 1'b1;
    tick();
    check("b_rise0", ifb.wr_req_o, 0);
    tick();
    check("b_rise1", ifb.wr_req_o, 0);
    ifb.vs_i = 1'b0;
    tick();
    check("b_fall", ifb.wr_req_o, 1);
    ifb.wr_ack_i = 1'b1;
    tick();
    ifb.wr_ack_i = 1'b0;
    check("b_drop", ifb.wr_req_o, 0);
    ifb.wr_done_i = 1'b1;
    tick();
    ifb.wr_done_i = 1'b0;
    tick();
    check("b_bufn1", ifb.bufn_o, 1);
    check("b_upd", ifb.buf_upd_o, 1);
    check("b_frame", ifb.frame_cnt_o, 1);
    ifb.rd_bufn_i = 8'd2;
    ifb.vs_i = 1'b1;
    tick();
    tick();
    ifb.vs_i = 1'b0;
    tick();
    check("b_fall2", ifb.wr_req_o, 1);
    ifb.wr_ack_i = 1'b1;
    tick();
    ifb.wr_ack_i = 1'b0;
    ifb.wr_done_i = 1'b1;
    tick();
    ifb.wr_done_i = 1'b0;
    tick();
    check("b_noskip", ifb.bufn_o, 2);
    check("b_skip_cnt", ifb.skip_cnt_o, 0);

    tick();
    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
